// File: rtl/vend_ctrl_if.sv
// Vending controller bus: coin/selection/cancel inputs, dispenser handshake and status outputs.
// master drives the user-side inputs, slave is the controller.
interface vend_ctrl_if #(
  parameter int unsigned CREDIT_W = 4
);
  logic [1:0]          in;
  logic                sel_valid;
  logic [1:0]          sel_id;
  logic                cancel;
  logic                disp_ack;
  logic                disp_req;
  logic [1:0]          disp_id;
  logic                change;
  logic                reject;
  logic                insuf;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  modport master (
    output in, sel_valid, sel_id, cancel, disp_ack,
    input  disp_req, disp_id, change, reject, insuf, credit, busy
  );

  modport slave (
    input  in, sel_valid, sel_id, cancel, disp_ack,
    output disp_req, disp_id, change, reject, insuf, credit, busy
  );
endinterface

// File: rtl/vend_ctrl.sv
// 4-product vending transaction controller: coin credit, price check, dispenser
// req/ack handshake and one-unit-per-cycle change payout.
module vend_ctrl #(
  parameter int unsigned PRICE0   = 3,
  parameter int unsigned PRICE1   = 4,
  parameter int unsigned PRICE2   = 5,
  parameter int unsigned PRICE3   = 6,
  parameter int unsigned CREDIT_W = 4,
  parameter int unsigned TIMEOUT  = 15
) (
  input logic         clk,
  input logic         rst,
  vend_ctrl_if.slave  bus
);

  localparam int unsigned SUM_W      = CREDIT_W + 1;
  localparam int unsigned CREDIT_MAX = (1 << CREDIT_W) - 1;
  localparam int unsigned CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                disp_req_q, disp_req_d;
  logic [1:0]          disp_id_q, disp_id_d;
  logic                change_q, change_d;
  logic                reject_q, reject_d;
  logic                insuf_q, insuf_d;
  logic                busy_q, busy_d;

  logic                coin_any;
  logic                coin_valid;
  logic                coin_bad;
  logic                coin_fits;
  logic [SUM_W-1:0]    coin_sum;
  logic [CREDIT_W-1:0] sel_price;

  function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] id);
    case (id)
      2'd0:    price_of = CREDIT_W'(PRICE0);
      2'd1:    price_of = CREDIT_W'(PRICE1);
      2'd2:    price_of = CREDIT_W'(PRICE2);
      default: price_of = CREDIT_W'(PRICE3);
    endcase
  endfunction

  // Coin decode; the one extra sum bit makes the overflow check exact.
  assign coin_any   = (bus.in != 2'b00);
  assign coin_bad   = (bus.in == 2'b11);
  assign coin_valid = coin_any && !coin_bad;
  assign coin_sum   = SUM_W'(credit_q) + SUM_W'(bus.in);
  assign coin_fits  = (coin_sum <= SUM_W'(CREDIT_MAX));
  assign sel_price  = price_of(bus.sel_id);

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    cnt_d      = cnt_q;
    disp_req_d = disp_req_q;
    disp_id_d  = disp_id_q;
    change_d   = 1'b0;
    reject_d   = 1'b0;
    insuf_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (coin_bad) begin
          reject_d = 1'b1;
        end else if (coin_valid) begin
          credit_d = CREDIT_W'(bus.in);
          cnt_d    = '0;
          state_d  = COLLECT;
        end
        insuf_d = bus.sel_valid;
      end

      COLLECT: begin
        if (bus.cancel) begin
          reject_d = coin_any;
          state_d  = CHANGE;
        end else if (bus.sel_valid && (credit_q >= sel_price)) begin
          credit_d   = credit_q - sel_price;
          disp_id_d  = bus.sel_id;
          disp_req_d = 1'b1;
          reject_d   = coin_any;
          state_d    = DISPENSE;
        end else begin
          insuf_d = bus.sel_valid;
          if (coin_valid && coin_fits) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            cnt_d    = '0;
          end else begin
            // Any cycle without an accepted coin advances the refund timer.
            reject_d = coin_any;
            if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
              state_d = CHANGE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end

      DISPENSE: begin
        reject_d = coin_any;
        if (bus.disp_ack) begin
          disp_req_d = 1'b0;
          state_d    = (credit_q != '0) ? CHANGE : IDLE;
        end
      end

      CHANGE: begin
        reject_d = coin_any;
        if (credit_q == '0) begin
          state_d = IDLE;
        end else begin
          change_d = 1'b1;
          credit_d = credit_q - CREDIT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == DISPENSE) || (state_d == CHANGE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      cnt_q      <= '0;
      disp_req_q <= 1'b0;
      disp_id_q  <= 2'd0;
      change_q   <= 1'b0;
      reject_q   <= 1'b0;
      insuf_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      cnt_q      <= cnt_d;
      disp_req_q <= disp_req_d;
      disp_id_q  <= disp_id_d;
      change_q   <= change_d;
      reject_q   <= reject_d;
      insuf_q    <= insuf_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.disp_req = disp_req_q;
  assign bus.disp_id  = disp_id_q;
  assign bus.change   = change_q;
  assign bus.reject   = reject_q;
  assign bus.insuf    = insuf_q;
  assign bus.credit   = credit_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model.
module tb_vend_ctrl;

  localparam int unsigned CW = 4;
  localparam int unsigned TO = 15;
  localparam int          MAXC = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vend_ctrl_if #(.CREDIT_W(CW)) vif ();

  vend_ctrl #(
    .PRICE0(3), .PRICE1(4), .PRICE2(5), .PRICE3(6),
    .CREDIT_W(CW), .TIMEOUT(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;
  int price [4] = '{3, 4, 5, 6};

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: what the machine is doing plus remaining credit.
  typedef enum int {M_IDLE, M_COLLECT, M_DISP, M_PAY} phase_t;
  phase_t ph;
  int m_credit, m_idle, m_id;
  bit m_req, m_change, m_reject, m_insuf;

  task automatic model_step(input int c, input bit s, input int id, input bit cn, input bit ack);
    m_change = 0; m_reject = 0; m_insuf = 0;
    case (ph)
      M_IDLE: begin
        if (c == 3) m_reject = 1;
        else if (c != 0) begin m_credit = c; m_idle = 0; ph = M_COLLECT; end
        if (s) m_insuf = 1;
      end
      M_COLLECT: begin
        if (cn) begin
          m_reject = (c != 0);
          ph = M_PAY;
        end else if (s && m_credit >= price[id]) begin
          m_credit -= price[id];
          m_req = 1; m_id = id;
          m_reject = (c != 0);
          ph = M_DISP;
        end else begin
          bit took;
          took = 0;
          if (s) m_insuf = 1;
          if (c == 1 || c == 2) begin
            if (m_credit + c <= MAXC) begin m_credit += c; took = 1; end
            else m_reject = 1;
          end else if (c == 3) m_reject = 1;
          if (took) m_idle = 0;
          else begin
            m_idle++;
            if (m_idle == int'(TO)) ph = M_PAY;
          end
        end
      end
      M_DISP: begin
        m_reject = (c != 0);
        if (ack) begin m_req = 0; ph = (m_credit > 0) ? M_PAY : M_IDLE; end
      end
      default: begin
        m_reject = (c != 0);
        if (m_credit == 0) ph = M_IDLE;
        else begin m_change = 1; m_credit--; end
      end
    endcase
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph = M_IDLE; m_credit = 0; m_idle = 0; m_id = 0;
      m_req = 0; m_change = 0; m_reject = 0; m_insuf = 0;
    end else begin
      model_step(int'(vif.in), vif.sel_valid, int'(vif.sel_id), vif.cancel, vif.disp_ack);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("disp_req", int'(vif.disp_req), int'(m_req));
      if (m_req) check("disp_id", int'(vif.disp_id), m_id);
      check("change", int'(vif.change), int'(m_change));
      check("reject", int'(vif.reject), int'(m_reject));
      check("insuf", int'(vif.insuf), int'(m_insuf));
      check("credit", int'(vif.credit), m_credit);
      check("busy", int'(vif.busy), int'(ph == M_DISP || ph == M_PAY));
    end
  end

  task automatic step(input logic [1:0] c, input bit s, input logic [1:0] id,
                      input bit cn, input bit ack);
    vif.in = c; vif.sel_valid = s; vif.sel_id = id; vif.cancel = cn; vif.disp_ack = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic count_change(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      step(2'd0, 0, 2'd0, 0, 0);
      cnt += int'(vif.change);
    end
  endtask

  int pulses;
  int quiet;

  initial begin
    rst = 1'b0;
    vif.in = 2'd0; vif.sel_valid = 0; vif.sel_id = 2'd0; vif.cancel = 0; vif.disp_ack = 0;
    #7;
    check("rst_disp_req", int'(vif.disp_req), 0);
    check("rst_credit", int'(vif.credit), 0);
    check("rst_busy", int'(vif.busy), 0);
    check("rst_change", int'(vif.change), 0);
    check("rst_reject", int'(vif.reject), 0);
    check("rst_insuf", int'(vif.insuf), 0);
    rst = 1'b1;
    chk_en = 1;

    // Exact price on product 1.
    step(2'd2, 0, 2'd0, 0, 0);
    step(2'd2, 0, 2'd0, 0, 0);
    check("t1_credit4", int'(vif.credit), 4);
    step(2'd0, 1, 2'd1, 0, 0);
    check("t1_req", int'(vif.disp_req), 1);
    check("t1_id", int'(vif.disp_id), 1);
    check("t1_credit0", int'(vif.credit), 0);
    step(2'd0, 0, 2'd0, 0, 1);
    check("t1_req_low", int'(vif.disp_req), 0);
    count_change(3, pulses);
    check("t1_no_change", pulses, 0);
    check("t1_idle_busy", int'(vif.busy), 0);

    // Overpay product 0: 6 - 3 leaves 3 units of change.
    repeat (3) step(2'd2, 0, 2'd0, 0, 0);
    check("t2_credit6", int'(vif.credit), 6);
    step(2'd0, 1, 2'd0, 0, 0);
    check("t2_credit3", int'(vif.credit), 3);
    check("t2_model_credit", m_credit, 3);
    step(2'd0, 0, 2'd0, 0, 1);
    count_change(6, pulses);
    check("t2_pulses", pulses, 3);
    check("t2_credit_end", int'(vif.credit), 0);

    // Insufficient, then top-up for product 3.
    step(2'd2, 0, 2'd0, 0, 0);
    step(2'd0, 1, 2'd3, 0, 0);
    check("t3_insuf", int'(vif.insuf), 1);
    check("t3_credit2", int'(vif.credit), 2);
    step(2'd2, 0, 2'd0, 0, 0);
    step(2'd2, 0, 2'd0, 0, 0);
    step(2'd0, 1, 2'd3, 0, 0);
    check("t3_req", int'(vif.disp_req), 1);
    check("t3_id", int'(vif.disp_id), 3);
    check("t3_credit0", int'(vif.credit), 0);
    step(2'd0, 0, 2'd0, 0, 1);
    step(2'd0, 0, 2'd0, 0, 0);

    // Overflow boundary and invalid coin.
    repeat (7) step(2'd2, 0, 2'd0, 0, 0);
    check("t4_credit14", int'(vif.credit), 14);
    step(2'd2, 0, 2'd0, 0, 0);
    check("t4_ovf_reject", int'(vif.reject), 1);
    check("t4_ovf_credit", int'(vif.credit), 14);
    step(2'd1, 0, 2'd0, 0, 0);
    check("t4_credit15", int'(vif.credit), 15);
    step(2'd3, 0, 2'd0, 0, 0);
    check("t4_bad_reject", int'(vif.reject), 1);
    step(2'd0, 0, 2'd0, 1, 0);
    count_change(18, pulses);
    check("t4_pulses", pulses, 15);

    // Cancel with a coin in the same cycle.
    step(2'd1, 0, 2'd0, 0, 0);
    step(2'd2, 0, 2'd0, 0, 0);
    step(2'd2, 0, 2'd0, 1, 0);
    check("t5_cancel_reject", int'(vif.reject), 1);
    check("t5_credit3", int'(vif.credit), 3);
    count_change(5, pulses);
    check("t5_pulses", pulses, 3);

    // Timeout refund: still collecting after TIMEOUT-1 idle cycles, refunding after TIMEOUT.
    step(2'd2, 0, 2'd0, 0, 0);
    repeat (TO - 1) step(2'd0, 0, 2'd0, 0, 0);
    check("t5_pre_to_busy", int'(vif.busy), 0);
    check("t5_pre_to_credit", int'(vif.credit), 2);
    step(2'd0, 0, 2'd0, 0, 0);
    check("t5_to_busy", int'(vif.busy), 1);
    count_change(5, pulses);
    check("t5_to_pulses", pulses, 2);

    // Asynchronous reset while dispensing.
    step(2'd2, 0, 2'd0, 0, 0);
    step(2'd2, 0, 2'd0, 0, 0);
    step(2'd0, 1, 2'd0, 0, 0);
    check("t6_req", int'(vif.disp_req), 1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_req", int'(vif.disp_req), 0);
    check("t6_async_credit", int'(vif.credit), 0);
    check("t6_async_busy", int'(vif.busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(2'd0, 0, 2'd0, 0, 1);
    check("t6_late_ack_req", int'(vif.disp_req), 0);
    check("t6_late_ack_busy", int'(vif.busy), 0);

    // Random traffic with occasional quiet stretches to reach the timeout.
    quiet = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] c;
      int r;
      r = int'($urandom_range(0, 99));
      if (quiet > 0) begin
        quiet--;
        step(2'd0, 0, 2'd0, 0, ($urandom_range(0, 2) == 0));
      end else begin
        if (r < 40)      c = 2'($urandom_range(1, 2));
        else if (r < 46) c = 2'd3;
        else             c = 2'd0;
        if ($urandom_range(0, 99) < 3) quiet = 20;
        step(c, ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0));
      end
    end

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
# vend_ctrl

Transaction controller for a 4-product vending machine with coin credit, selection, dispenser handshake and unit-by-unit change payout. It accepts coins on the same 2-bit coin encoding as the single-product vending FSM. It accumulates credit in units of 5, checks a selection against per-product prices, and sequences the external dispenser through a req/ack handshake. It then pays back any residual credit one coin per cycle and returns to idle.

## Interface
- PRICE0, 3: price of product 0, credit units (1 unit = 5).
- PRICE1, 4: price of product 1, units.
- PRICE2, 5: price of product 2, units.
- PRICE3, 6: price of product 3, units.
- CREDIT_W, 4: credit register width; max credit = 2^CREDIT_W-1.
- TIMEOUT, 15: idle cycles in COLLECT before automatic refund; must be ≥1.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous assert, active-low; all state and outputs cleared immediately.
- in  in  2  coin this cycle: 00 none, 01 = 1 unit, 10 = 2 units, 11 invalid.
- sel_valid  in  1  selection strobe, one cycle.
- sel_id  in  2  product index, sampled with sel_valid.
- cancel  in  1  refund request, one cycle.
- disp_ack  in  1  dispenser done; sampled only in DISPENSE.
- disp_req  out  1  dispense request, level, held until ack.
- disp_id  out  2  product being dispensed; stable while disp_req=1.
- change  out  1  one-cycle pulse per 1-unit coin returned.
- reject  out  1  one-cycle pulse: coin returned unaccepted.
- insuf  out  1  one-cycle pulse: selection refused, credit too low.
- credit  out  CREDIT_W  current credit, registered.
- busy  out  1  high in DISPENSE and CHANGE.

## Operation
- States: IDLE, COLLECT, DISPENSE, CHANGE. Reset → IDLE, credit=0, all outputs 0.
- IDLE:
  - Valid coin → credit=coin value, → COLLECT.
  - in=11 → reject pulse.
  - sel_valid → insuf pulse.
  - cancel → ignored.
- COLLECT:
  - Evaluation priority per cycle is cancel > sel_valid > coin.
  - cancel → CHANGE. A coin in the same cycle is rejected.
  - sel_valid with credit ≥ PRICE[sel_id]: credit -= price, disp_id=sel_id, disp_req=1, → DISPENSE. A coin in the same cycle is rejected.
  - sel_valid with credit < PRICE[sel_id]: insuf pulse, stay. A coin in the same cycle is processed normally.
  - Valid coin: credit += value if result ≤ 2^CREDIT_W-1; otherwise reject pulse and credit unchanged.
  - in=11 → reject pulse.
  - Timeout counter resets on every accepted coin and on entry. When it reaches TIMEOUT with no accepted coin → CHANGE.
- DISPENSE:
  - disp_req stays 1 until disp_ack is sampled 1.
  - On ack, disp_req=0 next cycle, then → CHANGE if credit>0, else → IDLE.
  - Coins are rejected. sel_valid and cancel are ignored.
- CHANGE:
  - Each cycle: change=1, credit -= 1.
  - When credit reaches 0, change=0 and → IDLE.
  - Entry with credit=0 (cancel or timeout at zero) → IDLE next cycle, no pulse.
  - Coins are rejected. sel_valid and cancel are ignored.
- Arithmetic is unsigned CREDIT_W bits. Overflow is prevented by the accept check. Underflow is impossible by construction.
- Reset mid-operation clears credit (forfeited), drops disp_req and change, and returns to IDLE.

## Timing
- All outputs are registered and update on the edge that samples the causing input. Effects are visible the cycle after stimulus.
- Coin-to-credit latency: 1 cycle.
- Selection-to-disp_req latency: 1 cycle.
- ack-to-disp_req-low latency: 1 cycle.
- Change payout: N pulses on N consecutive cycles, starting the cycle after entering CHANGE.
- disp_ack held high across the dispense cycle counts once. disp_ack outside DISPENSE is ignored.
- reject, insuf and change are single-cycle per event. Back-to-back events give consecutive pulses.
- busy equals (state==DISPENSE || state==CHANGE), registered with state.

## Test plan
- Reset, exact price: coins 10,10 then sel_id=1 (PRICE1=4) → disp_req=1, disp_id=1, credit=0; ack → IDLE, no change pulses.
- Overpay: coins 10,10,10 (credit 6), sel_id=0 (price 3) → dispense, then exactly 3 change pulses, credit 6→3→0, IDLE.
- Insufficient then top-up: credit 2, sel_id=3 → insuf pulse, credit 2; coins 10,10 (credit 6), sel_id=3 → dispense, credit 0.
- Overflow and invalid coins: coins up to credit 14, then 10 → reject, credit 14; 01 → credit 15; 11 → reject.
- Cancel/timeout: credit 3, cancel+coin same cycle → reject pulse, 3 change pulses. Separately, credit 2 idle for 15 cycles → 2 change pulses.
- Async reset mid-DISPENSE with disp_req=1 → disp_req, credit and busy are 0 immediately; later ack has no effect.
